// File: rtl/uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend
//
// Receives 8N1 UART bytes from an asynchronous serial pin. Each good byte is
// presented on a single-entry valid/ready buffer. Framing and overrun errors
// are reported as sticky flags.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (4..4095). The start bit is
//                  checked CLKS_PER_BIT/2 cycles into the bit. Every later
//                  bit is sampled one full bit period after the one before.
//
// Ports
//   clk        : single rising-edge clock
//   rst_n      : asynchronous active-low reset
//   rx         : raw serial line, idle high, asynchronous to clk
//   data_out   : received byte, held stable while data_valid is high
//   data_valid : data_out holds a byte the consumer has not yet taken
//   data_ready : consumer takes the byte on an edge where data_valid is high
//   frame_err  : sticky, a stop bit was sampled low
//   overrun    : sticky, a good byte arrived while the buffer was still full
//   clear_err  : synchronous clear of both sticky flags
// -----------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clear_err
);

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'((CLKS_PER_BIT / 2) - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic        rx_meta;
  logic        rx_s;
  logic [2:0]  state;
  logic [11:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift_reg;

  logic stop_sample;
  logic byte_good;
  logic load_byte;
  logic set_overrun;
  logic set_frame_err;

  // The stop-bit sample edge decides everything visible to the consumer.
  // A good byte may still load into a full buffer if the consumer empties it
  // on this same edge.
  assign stop_sample   = (state == STOP) && (cnt == BIT_LAST);
  assign byte_good     = stop_sample && rx_s;
  assign load_byte     = byte_good && (!data_valid || data_ready);
  assign set_overrun   = byte_good && data_valid && !data_ready;
  assign set_frame_err = stop_sample && !rx_s;

  // Two-flop synchronizer. It resets to the idle (high) level so that
  // releasing reset can never look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Bit-timing FSM. cnt is cleared at every sample point, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 12'd0;
      idx       <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= 12'd0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= 12'd0;
            idx <= 3'd0;
            // A line that is high again at mid-start-bit is treated as a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt       <= 12'd0;
            // LSB arrives first, so shift right and insert at the top.
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        STOP: begin
          if (stop_sample) begin
            cnt   <= 12'd0;
            // Returning to IDLE mid-stop-bit leaves margin for the next start.
            // A low stop bit may be a break, so wait for the line to go high.
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 12'd0;
        end
      endcase
    end
  end

  // Single-entry output buffer. A load on the same edge as a consume keeps
  // valid high with the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= 8'd0;
      data_valid <= 1'b0;
    end else if (load_byte) begin
      data_out   <= shift_reg;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky error flags. Setting a flag takes priority over clearing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_frame_err) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frontend
//
// Self-checking bench for uart_rx_frontend with CLKS_PER_BIT=8.
//
// Every edge number of the line level is recorded. A reference model works
// out each frame from that history using bit-centre arithmetic relative to
// the first low edge. A compare process checks the DUT outputs against the
// model on every falling clock edge outside reset. Directed scenarios add
// literal expectations. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int CPB      = 8;
  localparam int HALF     = CPB / 2;
  localparam int STOP_OFS = 2 + HALF + 9 * CPB;
  localparam int MAXC     = 30000;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_WAIT  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit rx_hist [0:MAXC-1];

  int         m_phase = M_IDLE;
  int         m_e0 = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;
  logic [7:0] m_byte;
  bit         m_load;
  bit         m_set_ov;
  bit         m_set_fe;

  int   rise_cyc = -1;
  int   m_rise_cyc = -1;
  logic prev_v = 1'b0;
  logic prev_mv = 1'b0;

  // Line level seen by the first synchronizer flop at edge i. Edges before
  // the bench starts and edges under reset count as idle.
  function automatic bit histAt(input int i);
    if (i < 1 || i >= MAXC) return 1'b1;
    return rx_hist[i];
  endfunction

  // Reference model, one step per rising edge. The start-bit check, the
  // data-bit samples and the stop-bit sample sit at fixed offsets from E0.
  // The DUT sees the line two edges late through the synchronizer.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      if (cyc < MAXC) rx_hist[cyc] = 1'b1;
      m_phase = M_IDLE;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
    end else begin
      if (cyc < MAXC) rx_hist[cyc] = rx;
      m_load   = 1'b0;
      m_set_ov = 1'b0;
      m_set_fe = 1'b0;
      if (m_phase == M_IDLE) begin
        if (histAt(cyc - 2) == 1'b0) begin
          m_e0    = cyc - 2;
          m_phase = M_FRAME;
        end
      end else if (m_phase == M_FRAME) begin
        if (cyc == m_e0 + 2 + HALF) begin
          if (histAt(m_e0 + HALF)) m_phase = M_IDLE;
        end else if (cyc == m_e0 + STOP_OFS) begin
          for (int k = 0; k < 8; k++) m_byte[k] = histAt(m_e0 + HALF + (k + 1) * CPB);
          if (histAt(m_e0 + HALF + 9 * CPB)) begin
            if (!m_valid || data_ready) m_load = 1'b1;
            else m_set_ov = 1'b1;
            m_phase = M_IDLE;
          end else begin
            m_set_fe = 1'b1;
            m_phase  = M_WAIT;
          end
        end
      end else begin
        if (histAt(cyc - 2)) m_phase = M_IDLE;
      end
      if (m_load) begin
        m_data  = m_byte;
        m_valid = 1'b1;
      end else if (m_valid && data_ready) begin
        m_valid = 1'b0;
      end
      if (m_set_fe) m_fe = 1'b1;
      else if (clear_err) m_fe = 1'b0;
      if (m_set_ov) m_ov = 1'b1;
      else if (clear_err) m_ov = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      checkOutput("model_data_valid", int'(data_valid), int'(m_valid));
      checkOutput("model_data_out",   int'(data_out),   int'(m_data));
      checkOutput("model_frame_err",  int'(frame_err),  int'(m_fe));
      checkOutput("model_overrun",    int'(overrun),    int'(m_ov));
    end
  end

  // Records the edge on which data_valid rose, for the DUT and for the model.
  always @(negedge clk) begin
    if (data_valid && !prev_v) rise_cyc = cyc;
    if (m_valid && !prev_mv) m_rise_cyc = cyc;
    prev_v  = data_valid;
    prev_mv = m_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame. e0 is the edge that first samples the start bit.
  // The line is left at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, output int e0);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  bit rand_done = 1'b0;

  initial begin
    int e0;
    int e0b;
    int tgt;
    int gap;

    // Reset values.
    repeat (3) tick();
    checkOutput("reset_data_out",   int'(data_out),   8'h00);
    checkOutput("reset_data_valid", int'(data_valid), 0);
    checkOutput("reset_frame_err",  int'(frame_err),  0);
    checkOutput("reset_overrun",    int'(overrun),    0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (5) tick();

    // Single byte with the consumer stalled.
    applyStimulus(8'hA5, 1'b1, e0);
    rx = 1'b1;
    repeat (4) tick();
    checkOutput("single_valid_latency", rise_cyc - e0, 78);
    checkOutput("single_model_latency", m_rise_cyc - e0, 78);
    checkOutput("single_data_out", int'(data_out), 8'hA5);
    checkOutput("single_model_data", int'(m_data), 8'hA5);
    consume();
    checkOutput("single_valid_falls", int'(data_valid), 0);
    repeat (5) tick();

    // Back-to-back frames into a full buffer.
    applyStimulus(8'h3C, 1'b1, e0);
    applyStimulus(8'hC3, 1'b1, e0);
    rx = 1'b1;
    repeat (4) tick();
    checkOutput("overrun_data_out", int'(data_out), 8'h3C);
    checkOutput("overrun_valid",    int'(data_valid), 1);
    checkOutput("overrun_flag",     int'(overrun), 1);
    checkOutput("overrun_no_fe",    int'(frame_err), 0);
    pulseClear();
    checkOutput("overrun_cleared",  int'(overrun), 0);
    consume();
    repeat (5) tick();

    // Consume and load on the same edge.
    applyStimulus(8'h11, 1'b1, e0);
    rx = 1'b1;
    repeat (4) tick();
    tgt = cyc + 1 + STOP_OFS;
    fork
      applyStimulus(8'h22, 1'b1, e0b);
      begin
        while (cyc < tgt - 1) tick();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
      end
    join
    rx = 1'b1;
    repeat (4) tick();
    checkOutput("simul_valid",    int'(data_valid), 1);
    checkOutput("simul_data_out", int'(data_out), 8'h22);
    checkOutput("simul_overrun",  int'(overrun), 0);
    consume();
    repeat (5) tick();

    // Framing error followed by a long low (break), then a good byte.
    applyStimulus(8'h55, 1'b0, e0);
    repeat (40) tick();
    rx = 1'b1;
    repeat (20) tick();
    checkOutput("frame_err_set",   int'(frame_err), 1);
    checkOutput("frame_no_byte",   int'(data_valid), 0);
    applyStimulus(8'h0F, 1'b1, e0);
    rx = 1'b1;
    repeat (4) tick();
    checkOutput("frame_next_valid", int'(data_valid), 1);
    checkOutput("frame_next_data",  int'(data_out), 8'h0F);
    consume();
    pulseClear();
    checkOutput("frame_err_cleared", int'(frame_err), 0);
    repeat (5) tick();

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (20) tick();
    checkOutput("glitch_valid", int'(data_valid), 0);
    checkOutput("glitch_fe",    int'(frame_err), 0);
    checkOutput("glitch_ov",    int'(overrun), 0);

    // Reset in the middle of the data bits, with a byte already buffered.
    applyStimulus(8'h5A, 1'b1, e0);
    rx = 1'b1;
    repeat (4) tick();
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midreset_data_out",  int'(data_out), 8'h00);
    checkOutput("midreset_valid",     int'(data_valid), 0);
    checkOutput("midreset_frame_err", int'(frame_err), 0);
    checkOutput("midreset_overrun",   int'(overrun), 0);
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    checkOutput("postreset_valid", int'(data_valid), 0);
    checkOutput("postreset_data",  int'(data_out), 8'h00);

    // Randomized traffic checked only against the model.
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          if ($urandom_range(0, 9) == 0) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            rx = 1'b1;
            repeat ($urandom_range(2, 10)) tick();
          end
          if ($urandom_range(0, 7) == 0) begin
            applyStimulus(8'($urandom), 1'b0, e0);
            repeat ($urandom_range(0, 30)) tick();
          end else begin
            applyStimulus(8'($urandom), 1'b1, e0);
          end
          rx = 1'b1;
          gap = $urandom_range(0, 12);
          repeat (gap) tick();
        end
        rx = 1'b1;
        repeat (30) tick();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          data_ready = ($urandom_range(0, 3) == 0);
          clear_err  = ($urandom_range(0, 49) == 0);
          tick();
        end
        data_ready = 1'b0;
        clear_err  = 1'b0;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("[TB] FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end for the TinyTapeout user design. It takes the asynchronous serial line from a dedicated input pin, recovers 8N1 UART bytes, and presents each byte on a single-entry valid/ready interface to the core logic in the top-level module. Framing and overrun errors are reported as sticky flags that the core can expose on output pins.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 4..4095. `HALF = CLKS_PER_BIT/2`, rounded down.
- `clk`, input, 1: the single clock; all state is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: raw serial line, asynchronous to `clk`, idle high.
- `data_out`, output, 8: received byte, LSB first on the wire.
- `data_valid`, output, 1: `data_out` holds an unconsumed byte.
- `data_ready`, input, 1: consumer accepts the byte on this edge when `data_valid` is also high.
- `frame_err`, output, 1: sticky; a stop bit was sampled low.
- `overrun`, output, 1: sticky; a good byte arrived while the buffer was still full.
- `clear_err`, input, 1: synchronous clear of both sticky flags.

## Operation
- **Synchronizer.** `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **Counters.** The bit counter is 12 bits wide and the bit index is 3 bits wide.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. The reset state is IDLE.
- **IDLE.**
  - If `rx_s`=0, go to START with cnt=0.
- **START.** cnt increments each cycle. When cnt==HALF-1:
  - If `rx_s`=0, go to DATA with cnt=0 and idx=0.
  - Otherwise the start was a glitch: go to IDLE with no flags set.
- **DATA.** cnt increments each cycle. When cnt==CLKS_PER_BIT-1:
  - Shift `rx_s` into bit 7 of the shift register, shifting right.
  - Set cnt=0.
  - If idx==7, go to STOP; otherwise idx increments.
- **STOP.** When cnt==CLKS_PER_BIT-1, sample `rx_s`:
  - **`rx_s`=1, buffer free or freed this edge:** load `data_out` from the shift register, set `data_valid`=1, go to IDLE.
  - **`rx_s`=1, buffer full and not consumed this edge:** set `overrun`=1, drop the new byte, leave `data_out` unchanged, go to IDLE.
  - **`rx_s`=0:** set `frame_err`=1, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE.**
  - Stay until `rx_s`=1, then go to IDLE.
  - This prevents a break condition from retriggering START.
- **Handshake.**
  - `data_valid` clears on an edge where `data_valid`&`data_ready` is true, unless a new byte loads on that same edge.
  - Consume and load on the same edge: `data_valid` stays 1, `data_out` takes the new byte, and no overrun is flagged.
  - `data_ready` while `data_valid`=0 has no effect.
  - `data_out` is held stable while `data_valid`=1.
- **Sticky flags.**
  - `clear_err` clears `frame_err` and `overrun` on the next edge.
  - If a set and `clear_err` occur on the same edge, the set wins.
  - Error events never affect `data_valid` or `data_out`.

## Timing
- **Reset values:** `data_out`=0x00, `data_valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, cnt=0, idx=0, shift register=0.
- **Reset mid-frame:** reset aborts immediately. After release the block waits in IDLE and resynchronizes on the next falling edge. A partially received byte is never delivered.
- **Edge naming:** E0 is the first `clk` edge at which the first synchronizer flop samples `rx` low.
- **Sample points:**
  - The start bit is checked at edge E0+2+HALF.
  - Data bit k (k=0..7) is sampled at edge E0+2+HALF+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge E0+2+HALF+9·CLKS_PER_BIT.
- **Output latency:** `data_valid`, `frame_err` and `overrun` update on the stop-sample edge.
- **Back-to-back frames:** the block returns to IDLE on the stop-sample edge, i.e. mid-stop-bit. The next start bit can therefore be detected without losing a frame at nominal baud, with ±4% clock mismatch tolerated.
- **Counter wrap:** cnt never wraps. It is reset to 0 at every sample point.

## Test plan
All scenarios use CLKS_PER_BIT=8 (HALF=4) and drive an ideal 8N1 waveform.
- **Reset:** assert `rst_n`=0 mid-DATA -> all outputs return to reset values. After release with `rx`=1 for 100 cycles, `data_valid` stays 0.
- **Single byte:** send 0xA5 with `data_ready`=0 -> `data_valid` rises exactly 78 edges after E0 with `data_out`=0xA5. Pulse `data_ready` once -> `data_valid` falls on that edge.
- **Overrun:** send 0x3C then 0xC3 back-to-back with `data_ready`=0 -> `data_out` stays 0x3C and `overrun`=1. Assert `clear_err` -> `overrun`=0.
- **Simultaneous consume and load:** send 0x11, then 0x22 with `data_ready` asserted exactly on the 0x22 stop-sample edge -> `data_valid` stays 1, `data_out`=0x22, `overrun`=0.
- **Framing error:** send 0x55 with the stop bit held low, then 40 cycles of low, then idle, then 0x0F -> `frame_err`=1, no byte is delivered for 0x55, no spurious frame occurs during the low period, and 0x0F is received correctly.
- **Glitch rejection:** drive `rx` low for 2 cycles, then high -> the FSM returns to IDLE, no flags are set, and `data_valid`=0.
